// File: rtl/my_btn_debounce2.sv
// Two-channel button conditioner: 2-flop synchroniser, per-channel debounce FSM,
// registered clean level plus one-cycle rise/fall pulses.
module my_btn_debounce2 #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a_db,
    output logic b_db,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    localparam int unsigned NCH = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOW  = 3'd0,
        S_RISE = 3'd1,
        S_HIGH = 3'd2,
        S_FALL = 3'd3
    } state_e;

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q, s2_q;
    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   db_q, db_d;
    logic [NCH-1:0]   rise_q, rise_d;
    logic [NCH-1:0]   fall_q, fall_d;

    assign raw = {b_raw, a_raw};

    // Per-channel filter: a level change is accepted only after DB_CYCLES
    // consecutive agreeing synced samples; any reversal restarts the count.
    always_comb begin
        for (int ch = 0; ch < int'(NCH); ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            db_d[ch]    = db_q[ch];
            rise_d[ch]  = 1'b0;
            fall_d[ch]  = 1'b0;
            case (state_q[ch])
                S_LOW: begin
                    db_d[ch] = 1'b0;
                    if (s2_q[ch]) begin
                        state_d[ch] = S_RISE;
                        cnt_d[ch]   = '0;
                    end
                end
                S_RISE: begin
                    db_d[ch] = 1'b0;
                    if (!s2_q[ch]) begin
                        state_d[ch] = S_LOW;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        state_d[ch] = S_HIGH;
                        cnt_d[ch]   = '0;
                        db_d[ch]    = 1'b1;
                        rise_d[ch]  = 1'b1;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    db_d[ch] = 1'b1;
                    if (!s2_q[ch]) begin
                        state_d[ch] = S_FALL;
                        cnt_d[ch]   = '0;
                    end
                end
                S_FALL: begin
                    db_d[ch] = 1'b1;
                    if (s2_q[ch]) begin
                        state_d[ch] = S_HIGH;
                        cnt_d[ch]   = '0;
                    end else if (cnt_q[ch] == CNT_LAST) begin
                        state_d[ch] = S_LOW;
                        cnt_d[ch]   = '0;
                        db_d[ch]    = 1'b0;
                        fall_d[ch]  = 1'b1;
                    end else begin
                        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[ch] = S_LOW;
                    cnt_d[ch]   = '0;
                    db_d[ch]    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int ch = 0; ch < int'(NCH); ch++) begin
                state_q[ch] <= S_LOW;
                cnt_q[ch]   <= '0;
            end
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int ch = 0; ch < int'(NCH); ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    assign a_db   = db_q[0];
    assign b_db   = db_q[1];
    assign a_rise = rise_q[0];
    assign a_fall = fall_q[0];
    assign b_rise = rise_q[1];
    assign b_fall = fall_q[1];

endmodule
